// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run controller.
// State encoding and reset/timeout default lengths live here.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TMO  = 2'd3
  } run_state_e;

  localparam int unsigned RST_CYCLES_DEF     = 5;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 10000;

endpackage

// File: rtl/retire_popcount.sv
// Combinational count of set bits in the per-hart retire vector.
// Output is wide enough to hold N_HARTS.
module retire_popcount #(
  parameter  int unsigned N_HARTS = 1,
  localparam int unsigned CW      = $clog2(N_HARTS + 1)
) (
  input  logic [N_HARTS-1:0] retire,
  output logic [CW-1:0]      count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N_HARTS; i++) begin
      count = count + CW'(retire[i]);
    end
  end

endmodule

// File: rtl/run_controller.sv
// Core reset sequencer and run monitor: holds cores in reset,
// counts run cycles and retires, then latches halt or timeout.
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int unsigned N_HARTS        = 1,
  parameter int unsigned RST_CYCLES     = RST_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CNT_W          = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [N_HARTS-1:0] hart_halt,
  input  logic [N_HARTS-1:0] hart_retire,
  input  logic [31:0]        exit_code,
  output logic               core_rst,
  output logic               running,
  output logic               done,
  output logic               timeout,
  output logic               pass,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam int unsigned PW      = $clog2(N_HARTS + 1);
  localparam logic [7:0]  HOLD_LEN = 8'(RST_CYCLES);
  localparam logic [63:0] TMO_LIM  = 64'(TIMEOUT_CYCLES);

  run_state_e       state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             pass_q, pass_d;
  logic             core_rst_q, core_rst_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;

  logic [PW-1:0]    pop;
  logic [CNT_W:0]   ret_sum;
  logic [CNT_W-1:0] ret_sat;
  logic [CNT_W-1:0] cyc_sat;
  logic             tmo_hit;

  retire_popcount #(
    .N_HARTS (N_HARTS)
  ) u_pop (
    .retire (hart_retire),
    .count  (pop)
  );

  always_comb begin
    ret_sum = {1'b0, retire_q} + (CNT_W + 1)'(pop);
    ret_sat = ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
    cyc_sat = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
    tmo_hit = (TIMEOUT_CYCLES != 0) && (64'(cycle_q) == TMO_LIM);
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    cycle_d  = cycle_q;
    retire_d = retire_q;
    pass_d   = pass_q;
    unique case (state_q)
      HOLD: begin
        if (hold_q == HOLD_LEN) begin
          state_d = RUN;
          cycle_d = CNT_W'(1);
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      RUN: begin
        retire_d = ret_sat;
        // Halt takes priority over a coincident timeout.
        if (&hart_halt) begin
          state_d = DONE;
          pass_d  = (exit_code == 32'd0);
        end else if (tmo_hit) begin
          state_d = TMO;
          pass_d  = 1'b0;
        end else begin
          cycle_d = cyc_sat;
        end
      end
      DONE, TMO: begin
        if (start) begin
          state_d  = HOLD;
          hold_d   = '0;
          cycle_d  = '0;
          retire_d = '0;
          pass_d   = 1'b0;
        end
      end
    endcase
    core_rst_d = (state_d != RUN);
    running_d  = (state_d == RUN);
    done_d     = (state_d == DONE);
    timeout_d  = (state_d == TMO);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= HOLD;
      hold_q     <= '0;
      cycle_q    <= '0;
      retire_q   <= '0;
      pass_q     <= 1'b0;
      core_rst_q <= 1'b1;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      cycle_q    <= cycle_d;
      retire_q   <= retire_d;
      pass_q     <= pass_d;
      core_rst_q <= core_rst_d;
      running_q  <= running_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign core_rst   = core_rst_q;
  assign running    = running_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign pass       = pass_q;
  assign cycle_cnt  = cycle_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_run_controller.sv
// Randomized bench for run_controller against a behavioural model.
// Two instances: wide counters/long timeout, and narrow/short.
module tb_run_controller;

  logic sys_clk;
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  // Instance A: 2 harts, default timeout, 32-bit counters
  logic        rst_a, start_a;
  logic [1:0]  halt_a, ret_a;
  logic [31:0] exit_a;
  logic        core_rst_a, running_a, done_a, timeout_a, pass_a;
  logic [31:0] cyc_a, rcnt_a;

  // Instance B: 3 harts, timeout 8, 4-bit counters
  logic        rst_b, start_b;
  logic [2:0]  halt_b, ret_b;
  logic [31:0] exit_b;
  logic        core_rst_b, running_b, done_b, timeout_b, pass_b;
  logic [3:0]  cyc_b, rcnt_b;

  run_controller #(.N_HARTS(2)) dut_a (
    .sys_clk(sys_clk), .sys_rst(rst_a), .start(start_a),
    .hart_halt(halt_a), .hart_retire(ret_a), .exit_code(exit_a),
    .core_rst(core_rst_a), .running(running_a), .done(done_a),
    .timeout(timeout_a), .pass(pass_a),
    .cycle_cnt(cyc_a), .retire_cnt(rcnt_a)
  );

  run_controller #(.N_HARTS(3), .TIMEOUT_CYCLES(8), .CNT_W(4)) dut_b (
    .sys_clk(sys_clk), .sys_rst(rst_b), .start(start_b),
    .hart_halt(halt_b), .hart_retire(ret_b), .exit_code(exit_b),
    .core_rst(core_rst_b), .running(running_b), .done(done_b),
    .timeout(timeout_b), .pass(pass_b),
    .cycle_cnt(cyc_b), .retire_cnt(rcnt_b)
  );

  // Model: cycles of reset hold still owed, plus outcome flags and counts.
  typedef struct {
    int     hold_left;
    bit     run;
    bit     dn;
    bit     tmo;
    bit     ps;
    longint cyc;
    longint ret;
  } mdl_t;

  mdl_t ma, mb;

  function automatic longint sat(longint v, longint cmax);
    return (v > cmax) ? cmax : v;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit rst, bit st, bit hlt,
                                 int pop, bit ez, longint lim,
                                 longint cmax, int rstc);
    mdl_t n = m;
    if (rst || ((m.dn || m.tmo) && st)) begin
      n.hold_left = rstc;
      n.run = 0; n.dn = 0; n.tmo = 0; n.ps = 0;
      n.cyc = 0; n.ret = 0;
    end else if (m.run) begin
      n.ret = sat(m.ret + longint'(pop), cmax);
      if (hlt) begin
        n.run = 0; n.dn = 1; n.ps = ez;
      end else if (lim != 0 && m.cyc == lim) begin
        n.run = 0; n.tmo = 1;
      end else begin
        n.cyc = sat(m.cyc + 1, cmax);
      end
    end else if (!m.dn && !m.tmo) begin
      if (m.hold_left == 0) begin
        n.run = 1; n.cyc = 1;
      end else begin
        n.hold_left--;
      end
    end
    return n;
  endfunction

  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick_a();
    @(posedge sys_clk);
    ma = mstep(ma, rst_a, start_a, &halt_a, $countones(ret_a),
               exit_a == 32'd0, 64'd10000, 64'hFFFF_FFFF, 5);
    #1;
    chk("a.core_rst", longint'(core_rst_a), longint'(!ma.run));
    chk("a.running",  longint'(running_a),  longint'(ma.run));
    chk("a.done",     longint'(done_a),     longint'(ma.dn));
    chk("a.timeout",  longint'(timeout_a),  longint'(ma.tmo));
    chk("a.pass",     longint'(pass_a),     longint'(ma.ps));
    chk("a.cycle",    longint'(cyc_a),      ma.cyc);
    chk("a.retire",   longint'(rcnt_a),     ma.ret);
  endtask

  task automatic tick_b();
    @(posedge sys_clk);
    mb = mstep(mb, rst_b, start_b, &halt_b, $countones(ret_b),
               exit_b == 32'd0, 64'd8, 64'd15, 5);
    #1;
    chk("b.core_rst", longint'(core_rst_b), longint'(!mb.run));
    chk("b.running",  longint'(running_b),  longint'(mb.run));
    chk("b.done",     longint'(done_b),     longint'(mb.dn));
    chk("b.timeout",  longint'(timeout_b),  longint'(mb.tmo));
    chk("b.pass",     longint'(pass_b),     longint'(mb.ps));
    chk("b.cycle",    longint'(cyc_b),      mb.cyc);
    chk("b.retire",   longint'(rcnt_b),     mb.ret);
  endtask

  task automatic rand_a(int n);
    for (int i = 0; i < n; i++) begin
      rst_a   = ($urandom_range(0, 63) == 0);
      start_a = ($urandom_range(0, 7) == 0);
      halt_a  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom);
      ret_a   = 2'($urandom);
      exit_a  = $urandom_range(0, 1) ? 32'd0 : $urandom;
      tick_a();
    end
    rst_a = 0; start_a = 0; halt_a = 0;
  endtask

  task automatic rand_b(int n);
    for (int i = 0; i < n; i++) begin
      rst_b   = ($urandom_range(0, 63) == 0);
      start_b = ($urandom_range(0, 7) == 0);
      halt_b  = ($urandom_range(0, 5) == 0) ? 3'b111 : 3'($urandom);
      ret_b   = 3'($urandom);
      exit_b  = $urandom_range(0, 1) ? 32'd0 : $urandom;
      tick_b();
    end
    rst_b = 0; start_b = 0; halt_b = 0;
  endtask

  task automatic run_a();
    int n;
    rst_a = 1; start_a = 0; halt_a = 0; ret_a = 0; exit_a = 0;
    tick_a();
    rst_a = 0;
    chk("a.rst_core", longint'(core_rst_a), 1);
    chk("a.rst_cyc",  longint'(cyc_a), 0);
    for (int i = 1; i <= 5; i++) begin
      start_a = (i == 3);
      tick_a();
      chk("a.hold_core", longint'(core_rst_a), 1);
    end
    start_a = 0;
    tick_a();
    chk("a.run_at6", longint'(running_a), 1);
    chk("a.cyc_at6", longint'(cyc_a), 1);
    for (int i = 0; i < 14; i++) begin
      ret_a   = (i < 10) ? 2'b11 : 2'b01;
      start_a = (i == 4);
      tick_a();
    end
    start_a = 0; ret_a = 2'b00; halt_a = 2'b11; exit_a = 0;
    tick_a();
    chk("a.ret24",   longint'(rcnt_a), 24);
    chk("a.done1",   longint'(done_a), 1);
    chk("a.pass1",   longint'(pass_a), 1);
    halt_a = 0;
    for (int i = 0; i < 5; i++) begin
      ret_a = 2'($urandom);
      tick_a();
    end
    chk("a.frozen24", longint'(rcnt_a), 24);
    start_a = 1;
    tick_a();
    start_a = 0;
    chk("a.restart_cyc", longint'(cyc_a), 0);
    chk("a.restart_ret", longint'(rcnt_a), 0);
    n = 0;
    while (!timeout_a && n < 10200) begin
      ret_a  = 2'($urandom);
      halt_a = 2'($urandom_range(0, 2));
      tick_a();
      n++;
    end
    chk("a.tmo_flag", longint'(timeout_a), 1);
    chk("a.tmo_cyc",  longint'(cyc_a), 10000);
    chk("a.tmo_pass", longint'(pass_a), 0);
    chk("a.tmo_core", longint'(core_rst_a), 1);
    halt_a = 0;
    start_a = 1;
    tick_a();
    start_a = 0;
    chk("a.tmo_clr", longint'(cyc_a), 0);
    for (int i = 1; i <= 6; i++) tick_a();
    chk("a.rerun", longint'(running_a), 1);
    rand_a(600);
  endtask

  task automatic run_b();
    int n;
    rst_b = 1; start_b = 0; halt_b = 0; ret_b = 0; exit_b = 0;
    tick_b();
    rst_b = 0;
    n = 0;
    while (!running_b && n < 20) begin tick_b(); n++; end
    n = 0;
    while (cyc_b != 4'd8 && n < 20) begin
      ret_b = 3'($urandom);
      tick_b();
      n++;
    end
    halt_b = 3'b111; exit_b = 32'd3;
    tick_b();
    chk("b.done_win", longint'(done_b), 1);
    chk("b.no_tmo",   longint'(timeout_b), 0);
    chk("b.pass0",    longint'(pass_b), 0);
    chk("b.cyc8",     longint'(cyc_b), 8);
    halt_b = 0;
    start_b = 1;
    tick_b();
    start_b = 0;
    n = 0;
    while (!running_b && n < 20) begin tick_b(); n++; end
    for (int i = 0; i < 7; i++) begin
      ret_b = (i < 6) ? 3'b111 : 3'b011;
      tick_b();
    end
    ret_b = 0;
    chk("b.ret_sat", longint'(rcnt_b), 15);
    rst_b = 1;
    tick_b();
    rst_b = 0;
    chk("b.mid_rst_core", longint'(core_rst_b), 1);
    chk("b.mid_rst_run",  longint'(running_b), 0);
    chk("b.mid_rst_ret",  longint'(rcnt_b), 0);
    chk("b.mid_rst_cyc",  longint'(cyc_b), 0);
    n = 0;
    while (!timeout_b && n < 40) begin tick_b(); n++; end
    chk("b.tmo_flag", longint'(timeout_b), 1);
    chk("b.tmo_cyc",  longint'(cyc_b), 8);
    rst_b = 1; start_b = 1;
    tick_b();
    rst_b = 0; start_b = 0;
    chk("b.rst_over_start", longint'(timeout_b), 0);
    rand_b(800);
  endtask

  initial begin
    fork
      run_a();
      run_b();
    join
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
